// File: rtl/pdp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pdp_mem_arbiter
//
// Shares the single data-memory port between instruction fetch (IF) and the
// operand read / write-back stage (D). Exactly one memory transaction is in
// flight at a time. Each requester uses a req/done handshake; the memory side
// uses req/ack.
//
// Priority is fixed D > IF. A starvation guard counts D grants issued while IF
// is waiting; once that count reaches STARVE_LIMIT, the next contended grant
// goes to IF.
//
// Optional feature (macro PDP_ARB_TIMEOUT_EN):
//   When defined, a BUSY cycle counter aborts an access that has not been
//   acknowledged within TIMEOUT_CYC cycles. The owner gets a done pulse with
//   all-ones read data, and arb_err pulses for one cycle.
//   When undefined, BUSY waits for mem_ack indefinitely and arb_err is tied 0.
//
// Ports
//   clock, reset    rising-edge clock, synchronous active-high reset
//   if_req/if_addr  fetch request and address (held until if_done)
//   if_done         one-cycle pulse, fetch complete
//   if_rdata        fetched word
//   d_req/d_we      data request and direction (held until d_done)
//   d_addr/d_wdata  data address and write data
//   d_done          one-cycle pulse, data access complete
//   d_rdata         read data (valid with d_done on reads)
//   mem_req         memory access active
//   mem_we          memory write enable
//   mem_addr        memory address
//   mem_wdata       memory write data
//   mem_ack         memory completes the current access this cycle
//   mem_rdata       memory read data, valid with mem_ack
//   arb_err         one-cycle pulse, access aborted by timeout
// -----------------------------------------------------------------------------
module pdp_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,   // 1..7
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_t            state_reg, state_next;
  logic              owner_d_reg, owner_d_next;     // 1: D owns the port
  logic [2:0]        starve_reg, starve_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              if_done_reg, if_done_next;
  logic              d_done_reg, d_done_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

  logic do_grant;       // arbitration happens this cycle
  logic grant_d;        // winner of this cycle's arbitration is D
  logic starve_full;    // IF has waited through STARVE_LIMIT D grants
  logic finish_ok;      // acknowledged completion in BUSY
  logic timeout;        // aborted completion in BUSY
  logic finish;

  assign starve_full = (starve_reg == STARVE_MAX);
  assign do_grant    = (state_reg == ST_IDLE) && (if_req || d_req);
  // D wins unless IF is also asking and has been passed over long enough.
  assign grant_d     = d_req && !(if_req && starve_full);
  // mem_ack is only meaningful while an access is outstanding.
  assign finish_ok   = (state_reg == ST_BUSY) && mem_ack;
  assign finish      = finish_ok || timeout;

  // ---------------------------------------------------------------------------
  // Optional BUSY timeout
  // ---------------------------------------------------------------------------
`ifdef PDP_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] busy_cnt_reg, busy_cnt_next;
  logic            arb_err_reg;

  // Every BUSY entry comes from IDLE, so clearing in IDLE clears on entry.
  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    if (state_reg == ST_IDLE) begin
      busy_cnt_next = '0;
    end else if (state_reg == ST_BUSY) begin
      busy_cnt_next = busy_cnt_reg + 1'b1;
    end
  end

  // The counter holds the number of BUSY cycles already elapsed, so the
  // TIMEOUT_CYC-th BUSY cycle is the one that sees TIMEOUT_CYC-1. A real
  // ack in that same cycle takes precedence over the abort.
  assign timeout = (state_reg == ST_BUSY) && !mem_ack &&
                   (busy_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt_reg <= '0;
      arb_err_reg  <= 1'b0;
    end else begin
      busy_cnt_reg <= busy_cnt_next;
      arb_err_reg  <= timeout;
    end
  end

  assign arb_err = arb_err_reg;
`else
  // TIMEOUT_CYC only matters when the abort logic is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout            = 1'b0;
  assign arb_err            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (if_req || d_req) state_next = ST_BUSY;
      ST_BUSY: if (finish)          state_next = ST_DONE;
      // Requests are deliberately not sampled here: requesters are still
      // reacting to their done pulse.
      ST_DONE:                      state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d_next   = owner_d_reg;
    starve_next    = starve_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    mem_req_next   = (state_next == ST_BUSY);
    if_done_next   = finish && !owner_d_reg;
    d_done_next    = finish && owner_d_reg;

    if (do_grant) begin
      owner_d_next = grant_d;
      if (grant_d) begin
        mem_we_next    = d_we;
        mem_addr_next  = d_addr;
        mem_wdata_next = d_wdata;
        // Only a D grant that overtakes a waiting IF counts toward starvation.
        if (if_req && !starve_full) begin
          starve_next = starve_reg + 3'd1;
        end
      end else begin
        // Fetches are always reads; mem_wdata keeps its last value.
        mem_we_next = 1'b0;
        mem_addr_next = if_addr;
        starve_next = '0;
      end
    end

    if (finish_ok) begin
      // Writes leave the owner's read-data register untouched.
      if (!mem_we_reg) begin
        if (owner_d_reg) begin
          d_rdata_next = mem_rdata;
        end else begin
          if_rdata_next = mem_rdata;
        end
      end
    end else if (timeout) begin
      if (owner_d_reg) begin
        d_rdata_next = '1;
      end else begin
        if_rdata_next = '1;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_d_reg   <= 1'b0;
      starve_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_done_reg   <= 1'b0;
      d_done_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      owner_d_reg   <= owner_d_next;
      starve_reg    <= starve_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_done_reg   <= if_done_next;
      d_done_reg    <= d_done_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_done   = if_done_reg;
  assign d_done    = d_done_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  // ---------------------------------------------------------------------------
  // Protocol checks: the owner must hold its request while the access is
  // outstanding. The transaction completes regardless; this only flags it.
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_if_req_held: assert property (@(posedge clock) disable iff (reset)
    (state_reg == ST_BUSY && !owner_d_reg) |-> if_req);
  a_d_req_held: assert property (@(posedge clock) disable iff (reset)
    (state_reg == ST_BUSY && owner_d_reg) |-> d_req);
`endif

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
module tb_pdp_mem_arbiter;

  localparam int STARVE = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ack;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_done, d_done, mem_req, mem_we, arb_err;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  pdp_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(STARVE), .TIMEOUT_CYC(8)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [15:0] if_addr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    int          waits;
    logic [15:0] rdata;
    logic        exp_d;        // 1: D expected to win
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_d_rdata;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {mem_req, mem_we, if_done, d_done, arb_err}, 5'b0);
    chk({name, "_data"}, {mem_addr, mem_wdata, if_rdata, d_rdata}, 64'h0);
  endtask

  // One complete transaction from IDLE, driven and checked from a table row.
  task automatic run_vec(input int i, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", i);
    if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_ack = 0; mem_rdata = 16'hDEAD;
    tick();
    chk({tag, "_grant_req"}, {mem_req, if_done, d_done}, 3'b100);
    chk({tag, "_grant_addr"}, mem_addr, v.exp_d ? v.d_addr : v.if_addr);
    chk({tag, "_grant_we"}, mem_we, v.exp_d ? v.d_we : 1'b0);
    if (v.exp_d && v.d_we) chk({tag, "_grant_wdata"}, mem_wdata, v.d_wdata);
    for (int w = 0; w < v.waits; w++) begin
      tick();
      chk({tag, "_wait"}, {mem_req, if_done, d_done}, 3'b100);
    end
    mem_ack = 1; mem_rdata = v.rdata;
    tick();
    mem_ack = 0; mem_rdata = 16'hDEAD;
    chk({tag, "_done"}, {mem_req, if_done, d_done}, {1'b0, !v.exp_d, v.exp_d});
    chk({tag, "_if_rdata"}, if_rdata, v.exp_if_rdata);
    chk({tag, "_d_rdata"}, d_rdata, v.exp_d_rdata);
    if_req = 0; d_req = 0;
    tick();
    chk({tag, "_pulse_end"}, {mem_req, if_done, d_done, arb_err}, 4'b0);
  endtask

  initial begin
    logic exp_seq[10];
    logic got[10];
    int   grants;

    //         if  d  we  if_addr   d_addr    wdata     w  rdata     expD if_rd     d_rd
    tbl[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h1234, 16'h0000};
    tbl[1] = '{0, 1, 0, 16'h0000, 16'h0300, 16'h0000, 1, 16'hA5A5, 1, 16'h1234, 16'hA5A5};
    tbl[2] = '{0, 1, 1, 16'h0000, 16'h0200, 16'hBEEF, 2, 16'h5A5A, 1, 16'h1234, 16'hA5A5};
    tbl[3] = '{1, 1, 0, 16'h0040, 16'h0400, 16'h0000, 1, 16'h1111, 1, 16'h1234, 16'h1111};
    tbl[4] = '{1, 1, 1, 16'h0041, 16'h0401, 16'h2222, 0, 16'h9999, 1, 16'h1234, 16'h1111};
    tbl[5] = '{1, 1, 0, 16'h0042, 16'h0402, 16'h0000, 0, 16'h3333, 1, 16'h1234, 16'h3333};
    tbl[6] = '{1, 1, 1, 16'h0043, 16'h0403, 16'h4444, 3, 16'h7777, 1, 16'h1234, 16'h3333};
    tbl[7] = '{1, 1, 0, 16'h0050, 16'h0500, 16'h0000, 0, 16'h5555, 0, 16'h5555, 16'h3333};
    tbl[8] = '{1, 1, 0, 16'h0051, 16'h0600, 16'h0000, 0, 16'h6666, 1, 16'h5555, 16'h6666};
    tbl[9] = '{1, 0, 0, 16'h0060, 16'h0000, 16'h0000, 1, 16'hABCD, 0, 16'hABCD, 16'h6666};

    // Reset state.
    do_reset();
    chk_all_zero("reset");

    // Spurious ack with nothing in flight is ignored.
    mem_ack = 1; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("spurious_ack");
    end
    mem_ack = 0;

    // Table-driven single transactions (also walks the starve count 0..4).
    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Both requesters held continuously: D,D,D,D,IF repeating.
    do_reset();
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    got = '{default: 1'bx};
    grants = 0;
    if_req = 1; if_addr = 16'h0070;
    d_req = 1; d_we = 0; d_addr = 16'h0700;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      mem_ack = mem_req;
      mem_rdata = 16'($urandom);
      tick();
      if (if_done || d_done) begin
        chk("done_exclusive", {if_done, d_done}, {if_done, 1'b0} | {1'b0, d_done & !if_done});
        if (grants < 10) got[grants] = d_done;
        grants++;
      end
    end
    chk("grant_count", grants, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("grant_order_%0d", i), got[i], exp_seq[i]);
    if_req = 0; d_req = 0; mem_ack = 0;
    tick();
    tick();

    // Reset while BUSY, ack arrives the cycle after reset.
    d_req = 1; d_we = 0; d_addr = 16'h0123;
    tick();
    chk("rst_busy_entered", mem_req, 1'b1);
    reset = 1; d_req = 0;
    tick();
    chk("rst_busy_req_drop", {mem_req, if_done, d_done}, 3'b000);
    reset = 0; mem_ack = 1; mem_rdata = 16'h4321;
    tick();
    chk_all_zero("late_ack");
    mem_ack = 0;
    tick();
    chk_all_zero("late_ack_after");

`ifdef PDP_ARB_TIMEOUT_EN
    // Unacknowledged D read aborts after 8 BUSY cycles; pending IF follows.
    do_reset();
    if_req = 1; if_addr = 16'h0090;
    d_req = 1; d_we = 0; d_addr = 16'h0900;
    tick();
    chk("to_grant_addr", mem_addr, 16'h0900);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_busy_%0d", i), {mem_req, if_done, d_done, arb_err}, 4'b1000);
    end
    tick();
    chk("to_abort", {mem_req, if_done, d_done, arb_err}, 4'b0011);
    chk("to_rdata", d_rdata, 16'hFFFF);
    d_req = 0;
    tick();
    chk("to_idle", {mem_req, if_done, d_done, arb_err}, 4'b0000);
    tick();
    chk("to_if_grant", {mem_req, mem_addr}, {1'b1, 16'h0090});
    mem_ack = 1; mem_rdata = 16'h0BAD;
    tick();
    mem_ack = 0; if_req = 0;
    chk("to_if_done", {if_done, if_rdata}, {1'b1, 16'h0BAD});
    tick();
`endif

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    begin
      int          phase;        // 0 free, 1 access outstanding, 2 done cycle
      logic        own_d;
      int          starve;
      logic        e_we, e_ifd, e_dd;
      logic [15:0] e_addr, e_wdata, e_ifr, e_dr;
      logic        p_if, p_d, p_we, p_ack;
      logic [15:0] p_ifa, p_da, p_dw, p_rd;
      int          wait_left;
      phase = 0; own_d = 0; starve = 0; wait_left = -1;
      e_we = 0; e_addr = 0; e_wdata = 0; e_ifr = 0; e_dr = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        // Requester agents: hold until done, then drop or re-request.
        if (if_req) begin
          if (if_done) begin
            if ($urandom_range(0, 1) == 0) if_req = 0;
            else if_addr = 16'($urandom);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = 16'($urandom);
        end
        if (d_req) begin
          if (d_done) begin
            if ($urandom_range(0, 1) == 0) d_req = 0;
            else begin d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom); end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
        // Memory agent: 0..3 wait states, occasional stray ack when idle.
        mem_rdata = 16'($urandom);
        if (mem_req) begin
          if (wait_left < 0) wait_left = $urandom_range(0, 3);
          if (wait_left == 0) begin mem_ack = 1; wait_left = -1; end
          else begin mem_ack = 0; wait_left--; end
        end else begin
          wait_left = -1;
          mem_ack = ($urandom_range(0, 7) == 0);
        end

        p_if = if_req; p_d = d_req; p_we = d_we; p_ack = mem_ack;
        p_ifa = if_addr; p_da = d_addr; p_dw = d_wdata; p_rd = mem_rdata;
        tick();

        e_ifd = 0; e_dd = 0;
        if (phase == 0) begin
          if (p_if || p_d) begin
            own_d = p_d && !(p_if && starve == STARVE);
            if (own_d) begin
              e_we = p_we; e_addr = p_da; e_wdata = p_dw;
              if (p_if && starve < STARVE) starve++;
            end else begin
              e_we = 0; e_addr = p_ifa; starve = 0;
            end
            phase = 1;
          end
        end else if (phase == 1) begin
          if (p_ack) begin
            if (own_d) begin e_dd = 1; if (!e_we) e_dr = p_rd; end
            else begin e_ifd = 1; e_ifr = p_rd; end
            phase = 2;
          end
        end else begin
          phase = 0;
        end

        chk("rnd_ctrl", {mem_req, if_done, d_done, arb_err}, {phase == 1, e_ifd, e_dd, 1'b0});
        chk("rnd_rdata", {if_rdata, d_rdata}, {e_ifr, e_dr});
        if (phase == 1) begin
          chk("rnd_mem", {mem_we, mem_addr}, {e_we, e_addr});
          if (e_we) chk("rnd_wdata", mem_wdata, e_wdata);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
